// File: rtl/fft_peak_detector.sv
// fft_peak_detector: streams an approximate magnitude for each FFT bin and
// reports the strongest bin of every N-point frame with a one-cycle done pulse.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   en_i, re_i, im_i      FFT output stream (signed Re/Im, valid strobe)
//   mag_o, mag_bin_o,
//   mag_valid_o           per-bin magnitude stream, two cycles after en_i
//   peak_bin_o,
//   peak_mag_o, done_o    frame peak, updated with done_o three cycles
//                         after the last sample of a frame
//   busy_o                a frame is partially received or still in flight
module fft_peak_detector #(
    parameter int bit_width = 28,
    parameter int N         = 32,
    parameter int SIZE      = 5,
    parameter int SKIP_DC   = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en_i,
    input  logic signed [bit_width-1:0] re_i,
    input  logic signed [bit_width-1:0] im_i,
    output logic        [bit_width:0]   mag_o,
    output logic                        mag_valid_o,
    output logic        [SIZE-1:0]      mag_bin_o,
    output logic        [SIZE-1:0]      peak_bin_o,
    output logic        [bit_width:0]   peak_mag_o,
    output logic                        done_o,
    output logic                        busy_o
);

    localparam logic [SIZE-1:0] LAST_BIN = SIZE'(N - 1);

    logic [SIZE-1:0]      cnt;

    // stage 1 registers
    logic                 valid1;
    logic [bit_width-1:0] ar;
    logic [bit_width-1:0] ai;
    logic [SIZE-1:0]      bin1;
    logic                 first1;
    logic                 last1;

    // stage 2 tags (data lives in mag_o / mag_bin_o)
    logic                 first2;
    logic                 last2;

    // stage 3 running best
    logic [bit_width:0]   best_mag;
    logic [SIZE-1:0]      best_bin;

    logic [bit_width-1:0] abs_re;
    logic [bit_width-1:0] abs_im;
    logic [bit_width-1:0] mx;
    logic [bit_width-1:0] mn;
    logic [bit_width:0]   mag_next;
    logic [bit_width:0]   eff;
    logic                 take;
    logic [bit_width:0]   new_mag;
    logic [SIZE-1:0]      new_bin;

    // Negating the most negative value wraps back onto itself, which read
    // as unsigned is exactly 2^(bw-1), so no saturation is needed.
    assign abs_re = re_i[bit_width-1] ? $unsigned(-re_i) : $unsigned(re_i);
    assign abs_im = im_i[bit_width-1] ? $unsigned(-im_i) : $unsigned(im_i);

    // alpha-max-plus-beta-min with alpha=1, beta=1/2
    assign mx       = (ar >= ai) ? ar : ai;
    assign mn       = (ar >= ai) ? ai : ar;
    assign mag_next = {1'b0, mx} + {2'b00, mn[bit_width-1:1]};

    // DC is still streamed on mag_o; it is only hidden from the search.
    assign eff = (SKIP_DC != 0 && mag_bin_o == '0) ? '0 : mag_o;

    // Strict greater-than keeps the earlier (lower) bin on ties.
    assign take    = first2 || (eff > best_mag);
    assign new_mag = take ? eff : best_mag;
    assign new_bin = take ? mag_bin_o : best_bin;

    assign busy_o = (cnt != '0) | valid1 | mag_valid_o | done_o;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            valid1      <= 1'b0;
            ar          <= '0;
            ai          <= '0;
            bin1        <= '0;
            first1      <= 1'b0;
            last1       <= 1'b0;
            mag_valid_o <= 1'b0;
            mag_o       <= '0;
            mag_bin_o   <= '0;
            first2      <= 1'b0;
            last2       <= 1'b0;
            best_mag    <= '0;
            best_bin    <= '0;
            peak_mag_o  <= '0;
            peak_bin_o  <= '0;
            done_o      <= 1'b0;
        end else begin
            valid1 <= en_i;
            if (en_i) begin
                ar     <= abs_re;
                ai     <= abs_im;
                bin1   <= cnt;
                first1 <= (cnt == '0);
                last1  <= (cnt == LAST_BIN);
                cnt    <= (cnt == LAST_BIN) ? '0 : cnt + 1'b1;
            end

            mag_valid_o <= valid1;
            if (valid1) begin
                mag_o     <= mag_next;
                mag_bin_o <= bin1;
                first2    <= first1;
                last2     <= last1;
            end

            done_o <= mag_valid_o && last2;
            if (mag_valid_o) begin
                best_mag <= new_mag;
                best_bin <= new_bin;
                if (last2) begin
                    peak_mag_o <= new_mag;
                    peak_bin_o <= new_bin;
                end
            end
        end
    end

endmodule
